// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, writeback FSM states and reset constants.
package cpu_pkg;

  localparam logic [5:0] OP_JMR   = 6'b000000;
  localparam logic [5:0] OP_CAR   = 6'b000011;
  localparam logic [5:0] OP_INC   = 6'b001000;
  localparam logic [5:0] OP_DEC   = 6'b001001;
  localparam logic [5:0] OP_ADD   = 6'b010001;
  localparam logic [5:0] OP_POP   = 6'b011011;
  localparam logic [5:0] OP_STORE = 6'b011100;
  localparam logic [5:0] OP_MULT  = 6'b100001;
  localparam logic [5:0] OP_JMD   = 6'b100011;
  localparam logic [5:0] OP_CALL  = 6'b100100;
  localparam logic [5:0] OP_RTN   = 6'b100110;
  localparam logic [5:0] OP_SEC   = 6'b101101;

  localparam logic [7:0]  STATUS_RST = 8'h00;
  localparam logic [11:0] SP_RST     = 12'h000;

  typedef enum logic {
    IDLE  = 1'b0,
    WB_HI = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_opclass.sv
// Combinational opcode classifier for the writeback stage.
module wb_opclass
  import cpu_pkg::*;
(
  input  logic [5:0] opcode_i,
  output logic       is_write_o,
  output logic       is_mult_o,
  output logic       is_pcload_o,
  output logic       is_stack_o
);

  always_comb begin
    is_write_o  = opcode_i inside {6'b000001, [6'b000110:6'b001110], [6'b010001:6'b010100],
                                   6'b011001, 6'b011010, 6'b011011,
                                   [6'b011101:6'b100000], 6'b100010};
    is_mult_o   = (opcode_i == OP_MULT);
    is_pcload_o = opcode_i inside {OP_JMR, OP_JMD, OP_CAR, OP_CALL, OP_RTN};
    // POP is the only register-writing op that also moves the stack pointer.
    is_stack_o  = opcode_i inside {OP_CAR, OP_CALL, OP_RTN, OP_POP};
  end

endmodule

// File: rtl/exec_writeback.sv
// Writeback stage after the ALU: register-file writes, two-cycle MULT writeback,
// PC loads, status and stack registers. Optional forwarding port under WB_FORWARD_EN.
module exec_writeback
  import cpu_pkg::*;
#(
  parameter int DW  = 16,
  parameter int AW  = 3,
  parameter int SPW = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ex_valid,
  output logic           ex_ready,
  input  logic [5:0]     encoded_opcode,
  input  logic [AW-1:0]  dest_addr,
  input  logic [DW-1:0]  aluout1,
  input  logic [DW-1:0]  aluout2,
  input  logic [7:0]     statusregout,
  input  logic [SPW-1:0] decremented_stack_reg,
  output logic           rf_we,
  output logic [AW-1:0]  rf_waddr,
  output logic [DW-1:0]  rf_wdata,
  output logic [7:0]     statusreg,
  output logic [SPW-1:0] stack_reg,
  output logic           pc_load,
  output logic [SPW-1:0] pc_value,
`ifdef WB_FORWARD_EN
  output logic           fwd_valid,
  output logic [AW-1:0]  fwd_addr,
  output logic [DW-1:0]  fwd_data,
`endif
  output wb_state_e      dbg_state
);

  // Handshake: a result transfers on a cycle where ex_valid and ex_ready are both
  // high; the upstream stage holds its op unchanged while ex_ready is low.

  logic is_write, is_mult, is_pcload, is_stack;
  logic accept;

  wb_state_e      state_q;
  logic           ex_ready_q;
  logic           rf_we_q;
  logic [AW-1:0]  rf_waddr_q;
  logic [DW-1:0]  rf_wdata_q;
  logic [7:0]     statusreg_q;
  logic [SPW-1:0] stack_reg_q;
  logic           pc_load_q;
  logic [SPW-1:0] pc_value_q;
  logic [AW-1:0]  hi_addr_q, hi_addr_d;
  logic [DW-1:0]  hi_data_q;

  wb_opclass u_opclass (
    .opcode_i    (encoded_opcode),
    .is_write_o  (is_write),
    .is_mult_o   (is_mult),
    .is_pcload_o (is_pcload),
    .is_stack_o  (is_stack)
  );

  assign accept    = ex_valid & ex_ready_q;
  assign hi_addr_d = dest_addr + AW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ex_ready_q  <= 1'b1;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      statusreg_q <= STATUS_RST;
      stack_reg_q <= SPW'(SP_RST);
      pc_load_q   <= 1'b0;
      pc_value_q  <= '0;
      hi_addr_q   <= '0;
      hi_data_q   <= '0;
    end else begin
      rf_we_q   <= 1'b0;
      pc_load_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            statusreg_q <= statusregout;
            if (is_stack) stack_reg_q <= decremented_stack_reg;
            if (is_pcload) begin
              pc_load_q  <= 1'b1;
              pc_value_q <= aluout1[SPW-1:0];
            end
            if (is_write || is_mult) begin
              rf_we_q    <= 1'b1;
              rf_waddr_q <= dest_addr;
              rf_wdata_q <= aluout1;
            end
            if (is_mult) begin
              hi_addr_q  <= hi_addr_d;
              hi_data_q  <= aluout2;
              state_q    <= WB_HI;
              ex_ready_q <= 1'b0;
            end
          end else begin
            // Reopens the input one cycle after the MULT high-half write.
            ex_ready_q <= 1'b1;
          end
        end
        WB_HI: begin
          rf_we_q    <= 1'b1;
          rf_waddr_q <= hi_addr_q;
          rf_wdata_q <= hi_data_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ex_ready  = ex_ready_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign statusreg = statusreg_q;
  assign stack_reg = stack_reg_q;
  assign pc_load   = pc_load_q;
  assign pc_value  = pc_value_q;
  assign dbg_state = state_q;

`ifdef WB_FORWARD_EN
  assign fwd_valid = rf_we_q;
  assign fwd_addr  = rf_waddr_q;
  assign fwd_data  = rf_wdata_q;
`endif

endmodule

// File: doc/exec_writeback.md
Name: exec_writeback

Overview:
- Stage directly downstream of the ALU.
- Registers the ALU results, status byte and stack pointer, and drives register-file writes.
- Sequences the two-cycle register write for MULT (low half, then high half).
- Issues PC loads for jump, call and return ops, and holds the architectural status register and stack pointer.

Parameters:
- DW, 16, data width of the register-file write port and of aluout1/aluout2
- AW, 3, register address width
- SPW, 12, stack pointer and PC width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  ALU result valid this cycle
- ex_ready  out  1  stage can accept a result; low while the MULT high half is pending
- encoded_opcode  in  6  opcode of the op in execute
- dest_addr  in  AW  destination register Rd
- aluout1  in  DW  primary ALU result (low half for MULT)
- aluout2  in  DW  MULT high half
- statusregout  in  8  next status byte computed by the ALU
- decremented_stack_reg  in  SPW  next stack pointer computed by the ALU
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  DW  register-file write data
- statusreg  out  8  architectural status register, fed back to the ALU statusregin
- stack_reg  out  SPW  architectural stack pointer, fed back to the ALU
- pc_load  out  1  one-cycle pulse: load PC
- pc_value  out  SPW  PC target

Behaviour:
- Accept: accept = ex_valid & ex_ready. All outputs are registered; each has 1-cycle latency from accept.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, statusreg=8'h00, stack_reg=12'h000, pc_load=0, pc_value=0, ex_ready=1, FSM=IDLE.
- Reset mid-MULT: abandons the pending high write with no write issued.
- Opcode classes:
  - WRITE: 000001, 000110–001110, 010001–010100, 011001, 011010, 011011, 011101–100000, 100010.
  - MULT: 100001.
  - JUMP: 000000, 100011.
  - CALLRET: 000011, 100100, 100110.
  - STACK-ONLY: 011011 (POP also writes the register).
  - Everything else (ghosts 010101/010110, STORE 011100, flag ops 101001–110110, BRU/BRD, undefined): no register write, no PC load.
- On every accept: statusreg <= statusregout. Flag ops and ghost ops rely on the ALU having already formed the correct byte.
- WRITE accept: rf_we=1, rf_waddr=dest_addr, rf_wdata=aluout1 for exactly one cycle.
- JUMP/CALLRET accept: pc_load=1 for one cycle; pc_value <= aluout1[SPW-1:0].
- CALLRET and POP accept: stack_reg <= decremented_stack_reg. All other ops leave stack_reg unchanged.
- FSM states:
  - IDLE: MULT accept → write aluout1 to dest_addr, latch aluout2 and dest_addr+1, go to WB_HI, ex_ready=0.
  - WB_HI: write latched aluout2 to the latched address; ex_ready returns to 1 next cycle; go to IDLE.
- Address wrap: dest_addr+1 wraps modulo 2^AW (Rd=7 → high half to R0).
- ex_valid is ignored while ex_ready=0. The upstream stage must hold its op; no result is lost or duplicated.
- Back-to-back accepts: ops in consecutive cycles each produce their own one-cycle rf_we. No bubble except after MULT.

Optional Feature:
- Macro WB_FORWARD_EN.
- Defined: adds outputs fwd_valid (1), fwd_addr (AW), fwd_data (DW), equal to the registered rf_we/rf_waddr/rf_wdata. This lets the operand fetch forward a result written in the same cycle it is read.
- Not defined: ports absent; no forwarding logic.

Decomposition:
- Shared package cpu_pkg:
  - 6-bit opcode localparams (OP_MULT, OP_JMR, OP_JMD, OP_CALL, OP_CAR, OP_RTN, OP_POP, ...)
  - wb state enum {IDLE, WB_HI}
  - reset constants STATUS_RST, SP_RST
- One combinational sub-module wb_opclass: maps encoded_opcode to is_write, is_mult, is_pcload and is_stack.

Test Plan:
- ADD (010001), dest=3, aluout1=16'h1234, ex_valid 1 cycle → next cycle rf_we=1, waddr=3, wdata=16'h1234; statusreg=statusregout; stack unchanged.
- MULT (100001), dest=7, aluout1=16'hBEEF, aluout2=16'h00A5 → cycle+1: write R7=BEEF with ex_ready=0; cycle+2: write R0=00A5; cycle+3: ex_ready=1. A second op held on ex_valid is accepted only at cycle+3.
- CALL (100100), aluout1=12'h0401, decremented_stack_reg=12'h011 → pc_load pulse, pc_value=12'h401, stack_reg=12'h011, rf_we=0.
- SEC (101101), statusregout=8'h44 → statusreg=8'h44, rf_we=0, pc_load=0.
- Reset asserted in WB_HI after MULT → next cycle rf_we=0, ex_ready=1, statusreg=8'h00, stack_reg=0; no high-half write ever appears.
- Back-to-back INC (001000), dest 1, then DEC (001001), dest 2 → two consecutive single-cycle writes to R1 then R2, with no bubble.
